// File: rtl/uart_irq_status_gen.sv
// UART interrupt status generator: builds the 8-bit status word from sticky error flags and
// registered level flags, and pushes changes downstream with a rate-limited write strobe.
`timescale 1ns/1ps

module uart_irq_status_gen #(
    parameter int unsigned HOLDOFF = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_fe_pulse,
    input  logic       i_crce_pulse,
    input  logic       i_ore_pulse,
    input  logic       i_nf_pulse,
    input  logic       i_txi,
    input  logic       i_tbnf,
    input  logic       i_dr,
    input  logic       i_clr,
    input  logic [3:0] i_clr_mask,
    input  logic [6:0] i_ien,
    output logic       o_wrien,
    output logic [7:0] o_idata,
    output logic       o_irq
);

    localparam int unsigned CntW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CntW-1:0] CntLoad = (HOLDOFF > 1) ? CntW'(HOLDOFF - 1) : '0;
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic {
        StIdle,
        StHold
    } state_e;

    logic [3:0]      r_sticky;
    logic [2:0]      r_level;
    logic [7:0]      r_shadow;
    logic [7:0]      r_idata;
    logic            r_wrien;
    logic            r_irq;
    logic [CntW-1:0] r_cnt;
    state_e          r_state;

    logic [3:0] w_pulses;
    logic [3:0] w_clr_bits;
    logic [7:0] w_status;
    logic       w_pending;

    assign w_pulses   = {i_nf_pulse, i_ore_pulse, i_crce_pulse, i_fe_pulse};
    assign w_clr_bits = i_clr ? i_clr_mask : 4'b0000;

    assign w_status[6:0] = {r_level, r_sticky};
    assign w_status[7]   = |(w_status[6:0] & i_ien);
    assign w_pending     = (w_status != r_shadow);

    // Set is OR-ed in after the clear so a same-edge pulse wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sticky <= 4'b0000;
            r_level  <= 3'b000;
            r_irq    <= 1'b0;
        end else begin
            r_sticky <= (r_sticky & ~w_clr_bits) | w_pulses;
            r_level  <= {i_dr, i_tbnf, i_txi};
            r_irq    <= w_status[7];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_shadow <= 8'h00;
            r_idata  <= 8'h00;
            r_wrien  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_pending) begin
                        r_wrien  <= 1'b1;
                        r_idata  <= w_status;
                        r_shadow <= w_status;
                        if (HOLDOFF > 1) begin
                            r_state <= StHold;
                            r_cnt   <= CntLoad;
                        end
                    end else begin
                        r_wrien <= 1'b0;
                    end
                end
                StHold: begin
                    r_wrien <= 1'b0;
                    // Leave on the edge the count reaches zero so writes are HOLDOFF edges apart.
                    if (r_cnt <= CntOne) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                    r_wrien <= 1'b0;
                end
            endcase
        end
    end

    assign o_wrien = r_wrien;
    assign o_idata = r_idata;
    assign o_irq   = r_irq;

endmodule

// File: doc/uart_irq_status_gen.md
Name: uart_irq_status_gen

Overview:
- Collects UART receiver/transmitter event and level flags into the 8-bit interrupt status word.
- Keeps error flags sticky until software clears them.
- Issues a rate-limited write strobe plus data word to the downstream interrupt status register (`wrien`/`idata` there).
- Also drives a masked interrupt request line to the CPU side.

Parameters:
- HOLDOFF, 4, minimum number of clk cycles between successive wrien pulses. 0 means no holdoff.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fe_pulse  in  1  frame-error event, 1-cycle pulse from receiver.
- crce_pulse  in  1  CRC-error event, 1-cycle pulse.
- ore_pulse  in  1  overrun event, 1-cycle pulse.
- nf_pulse  in  1  noise-flag event, 1-cycle pulse.
- txi  in  1  transmitter idle, level.
- tbnf  in  1  transmit buffer not full, level.
- dr  in  1  receive data ready, level.
- clr  in  1  sticky-flag clear strobe.
- clr_mask  in  4  selects which sticky bits clr clears. Bit0 = fe, bit1 = crce, bit2 = ore, bit3 = nf.
- ien  in  7  interrupt enable per status bit 6..0.
- wrien  out  1  write strobe to the status register, 1 cycle.
- idata  out  8  status word presented with wrien.
- irq  out  1  masked interrupt request, level.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. Asserting `rst_n` low clears all state immediately, regardless of clk.

Reset values:
- Sticky bits = 0; level-flag registers = 0; shadow = 0x00.
- idata = 0x00, wrien = 0, irq = 0.
- FSM = IDLE, holdoff counter = 0.

Status word S[7:0]:
- S[0] = fe, S[1] = crce, S[2] = ore, S[3] = nf (sticky bits).
- S[4] = txi, S[5] = tbnf, S[6] = dr (each registered one stage from its input).
- S[7] = |(S[6:0] & ien), the summary interrupt bit.

Sticky bits:
- A pulse sampled high at edge k sets the bit after edge k.
- With clr high and clr_mask[i]=1 at edge k, bit i clears after edge k.
- If a set and a clear hit the same bit on the same edge, set wins (the bit stays 1).
- clr with clr_mask = 0 has no effect.

irq:
- Registered each edge: irq <= S[7], computed from the current S.
- irq is not gated by the holdoff; it follows S with a 1-edge delay.

Write FSM (states IDLE, HOLD):
- pending = (S != shadow).
- IDLE, pending=1:
  - At the edge: wrien <= 1, idata <= S, shadow <= S.
  - Next state = HOLD with count = HOLDOFF-1. If HOLDOFF = 0, or HOLDOFF = 1, stay in IDLE.
- IDLE, pending=0: wrien <= 0.
- HOLD:
  - wrien <= 0, count decrements each edge.
  - When count = 0, go to IDLE.
  - Changes arriving during HOLD are not lost. They remain pending and are written on the first IDLE edge.
  - Intermediate values are coalesced; only the latest S is written.
- wrien is always exactly 1 cycle wide. idata holds its value between writes.
- With HOLDOFF = 0, back-to-back changes produce wrien on consecutive cycles.

Latency:
- Event pulse high before edge k, FSM idle → wrien = 1 and idata valid during the cycle after edge k+1.
- The downstream register captures at edge k+2.

Other boundary rules:
- Level inputs toggling and returning to the original value within HOLD produce no write if the final S equals shadow.
- After reset, level inputs that are already 1 (e.g. tbnf) cause a first write at the second edge after rst_n deasserts.
- Reset asserted mid-HOLD forces IDLE, count = 0, and drops any pending write.

Test Plan:
- Reset with all inputs 0, then 10 idle cycles → wrien never asserted; idata = 0x00; irq = 0.
- HOLDOFF=4, ien=0x01, fe_pulse one cycle before edge 5 → wrien high after edge 6 with idata = 0x81; irq = 1 after edge 6.
- HOLDOFF=4: crce_pulse before edge 10, ore_pulse before edge 11, nf_pulse before edge 12 → wrien after edge 11 with idata = 0x02, then a single wrien after edge 15 with idata = 0x0E (coalesced); exactly 2 pulses total.
- S = 0x0F, then clr=1 with clr_mask=0x5 together with a new fe_pulse on the same edge → S = 0x0B (fe kept by set-wins, ore cleared); wrien follows with idata = 0x0B when ien = 0.
- Hold tbnf=1 through reset release → first wrien at the second edge after deassertion with idata = 0x20; assert rst_n low mid-HOLD → wrien, idata and irq go to 0 immediately, no write after release until S changes.
- HOLDOFF=0: dr toggles 1,0,1 on consecutive edges → three consecutive wrien cycles with idata = 0x40, 0x00, 0x40.
